mos6502_agu: RTL and testbench
==============================

# mos6502_agu

Parametrised effective-address generator for the 6502-family core. The core's decoder starts it with an addressing-mode code. It then fetches operand bytes at the PC, performs pointer reads, and applies indexing, including page-cross detection and zero-page wrap. It returns the final effective address to the execute stage and stalls on a memory `ready` handshake, which the first-generation sequencer lacked.

## Interface
Parameters:
- `AW`, 16: address width, ≥16. Bits `AW-1:16` of every data EA come from `dbank`. Pointer and operand fetches use bank 0.
- `ZP_WRAP`, 1: 1 = ZPX/ZPY/NDX pointer arithmetic wraps mod 256. 0 = carry propagates into bits 15:8.

Ports:
- `clock`, in, 1: the single clock. All state changes on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request. Accepted only when `busy`=0.
- `mode`, in, 4: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABX, 6 ABY, 7 NDX, 8 NDY, 9 IND, 10 REL. Codes 11–15 behave as IMM.
- `force`, in, 1: store/RMW. The extra index cycle is taken unconditionally. Sampled with `start`.
- `x`, `y`, in, 8: index registers. Must be held stable while `busy`.
- `pc`, in, 16: operand pointer. The core increments it on `pc_adv`.
- `dbank`, in, `AW-16` (min 1): high EA bits.
- `din`, in, 8: read data. Valid in the same cycle as `address`.
- `ready`, in, 1: 0 = the memory cycle does not complete; hold everything.
- `address`, out, AW: bus address.
- `rd`, out, 1: read strobe.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: one-cycle pulse; `ea` is valid.
- `ea`, out, AW: effective address. Held until the next `done`.
- `pc_adv`, out, 1: one-cycle pulse per operand byte consumed.
- `page_x`, out, 1: page crossed (index or branch). Valid with `done`.

## Operation
- States: IDLE, OP1, OP2, DUMMY, PLO, PHI, FIX. The first cycle after acceptance is OP1, driving `address`=`pc`, `rd`=1.
- IMM: OP1 gives `ea`=`pc`, `pc_adv`, `done`. No byte is consumed from the data path.
- ZP: OP1 gives `ea`={0,din}, `done`.
- ZPX/ZPY: OP1 latches din, then DUMMY (dummy read at {0,din}) gives `ea`=din+idx, wrapped per `ZP_WRAP`.
- ABS: OP1 gives lo, OP2 gives hi; `ea`={dbank,hi,lo}.
- ABX/ABY: as ABS; sum = {hi,lo}+idx.
  - If a carry out of bit 7 occurs, or `force`: FIX cycle, dummy read at {hi,lo+idx low byte}, then `done` with the corrected address.
  - `page_x` = carry.
- NDX: OP1 gives ptr, DUMMY, PLO reads at (ptr+x), PHI reads at (ptr+x+1), both mod 256.
- NDY: OP1 gives ptr, PLO at ptr, PHI at ptr+1 (mod 256), then + y with the ABY FIX rule.
- IND: OP1/OP2 give ptr. PLO reads at ptr, PHI reads at ptr+1 (see Configuration). `ea` is the 16-bit target with `dbank` bits forced to 0.
- REL: OP1 gives `ea`=pc+1+sext(din), `page_x`=(ea[15:8]≠(pc+1)[15:8]). Branch-taken timing is the core's concern.
- `pc_adv` pulses in the OP1 and OP2 cycles only.
- `rd`=1 in every non-IDLE cycle.
- `address` in IDLE = `pc`.

## Timing
- Reset values: `address`=`pc` (combinational), all other outputs 0; state IDLE.
- Reset mid-sequence aborts at once. No `done` is issued.
- Cycles from acceptance to `done` inclusive, with `ready`=1:
  - IMM 1, ZP 1, REL 1
  - ZPX/ZPY 2, ABS 2
  - ABX/ABY 2, or 3 with cross/force
  - NDX 4
  - NDY 3, or 4 with cross/force
  - IND 4
- `done` is asserted in the last sequence cycle; `busy` falls in the same edge. A new `start` is accepted the following cycle.
- `start` while `busy` is ignored, not queued.
- `ready`=0 adds exactly one cycle per low cycle:
  - state, `address`, `rd` held;
  - no `pc_adv`, no `done`, din ignored.

## Configuration
- `NMOS_JMP_BUG_EN` defined: IND PHI address = {ptr_hi, ptr_lo+1 mod 256}, the NMOS page-wrap bug.
- Not defined: PHI address = ptr+1 with full 16-bit carry (CMOS behaviour).
- Cycle count is identical either way.

## Test plan
- ABX with x=0x10 and operand bytes 0xF8,0x12: `ea`=0x1308, `page_x`=1, `done` on cycle 3. Same with x=0x01: `ea`=0x12F9, `done` on cycle 2.
- NDX ptr=0xFF, x=0x01, mem[0x00]=0x34, mem[0x01]=0x12: `ea`=0x1234, 4 cycles, reads at 0x00 and 0x01.
- IND ptr=0x02FF, mem[0x02FF]=0x00, mem[0x0200]=0x80, mem[0x0300]=0x90: `ea`=0x8000 with `NMOS_JMP_BUG_EN`, 0x9000 without.
- ZP with `ready` low for 3 cycles during OP1: `done` on cycle 4, `address` stable throughout, a single `pc_adv` pulse.
- REL pc=0x10FD, offset 0x05: `ea`=0x1103, `page_x`=1. Offset 0xFE: `ea`=0x10FC, `page_x`=0.
- `reset_n` low in NDY PLO, then `start` with IMM: no stale `done`; IMM `done` arrives 1 cycle after acceptance.

Source files
------------

// File: rtl/mos6502_agu.sv
// -----------------------------------------------------------------------------
// mos6502_agu -- effective-address generator for the 6502-family core.
//
// The decoder starts a sequence with an addressing-mode code. The block fetches
// operand bytes at the PC, performs zero-page / indirect pointer reads and
// applies X/Y indexing, including page-cross detection and the extra fix-up
// cycle. Every memory cycle can be stretched by holding ready_i low.
//
// Parameters:
//   AW      : bus / effective-address width (>= 16). Bits AW-1:16 of data
//             addresses come from dbank_i; operand and pointer fetches use
//             bank 0.
//   ZP_WRAP : 1 = ZPX/ZPY/NDX pointer arithmetic wraps mod 256,
//             0 = the carry propagates into bits 15:8.
//
// Compile-time option:
//   NMOS_JMP_BUG_EN : when defined, the IND high-byte pointer read wraps inside
//                     the pointer's page (NMOS JMP ($xxFF) behaviour). When
//                     undefined the pointer increments across the page.
//
// Ports:
//   clock_i    : clock, all state changes on the rising edge
//   reset_n_i  : asynchronous active-low reset
//   start_i    : request, accepted only while busy_o = 0
//   mode_i     : addressing mode (0 IMM .. 10 REL, 11-15 behave as IMM)
//   force_i    : store/RMW, always take the index fix-up cycle
//   x_i, y_i   : index registers, stable while busy_o
//   pc_i       : operand pointer, advanced by the core on pc_adv_o
//   dbank_i    : high data-address bits
//   din_i      : read data, valid in the same cycle as address_o
//   ready_i    : 0 = memory cycle does not complete, everything holds
//   address_o  : bus address (pc_i while idle)
//   rd_o       : read strobe, high in every non-idle cycle
//   busy_o     : sequence in progress
//   done_o     : one-cycle pulse, ea_o valid
//   ea_o       : effective address, held until the next done_o
//   pc_adv_o   : one pulse per operand byte consumed
//   page_x_o   : page crossed (index or branch), valid with done_o
// -----------------------------------------------------------------------------
module mos6502_agu #(
    parameter int AW      = 16,
    parameter bit ZP_WRAP = 1'b1,
    localparam int BW     = (AW > 16) ? (AW - 16) : 1
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          start_i,
    input  logic [3:0]    mode_i,
    input  logic          force_i,
    input  logic [7:0]    x_i,
    input  logic [7:0]    y_i,
    input  logic [15:0]   pc_i,
    input  logic [BW-1:0] dbank_i,
    input  logic [7:0]    din_i,
    input  logic          ready_i,
    output logic [AW-1:0] address_o,
    output logic          rd_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] ea_o,
    output logic          pc_adv_o,
    output logic          page_x_o
);

    localparam logic [3:0] M_IMM = 4'd0;
    localparam logic [3:0] M_ZP  = 4'd1;
    localparam logic [3:0] M_ZPX = 4'd2;
    localparam logic [3:0] M_ZPY = 4'd3;
    localparam logic [3:0] M_ABS = 4'd4;
    localparam logic [3:0] M_ABX = 4'd5;
    localparam logic [3:0] M_ABY = 4'd6;
    localparam logic [3:0] M_NDX = 4'd7;
    localparam logic [3:0] M_NDY = 4'd8;
    localparam logic [3:0] M_IND = 4'd9;
    localparam logic [3:0] M_REL = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OP1   = 3'd1,
        S_OP2   = 3'd2,
        S_DUMMY = 3'd3,
        S_PLO   = 3'd4,
        S_PHI   = 3'd5,
        S_FIX   = 3'd6
    } state_e;

    // Data-space address: the 16-bit offset placed in the data bank.
    function automatic logic [AW-1:0] data_addr(input logic [BW-1:0] bank,
                                                input logic [15:0]   a16);
        logic [AW-1:0] hi_part;
        hi_part = AW'(bank) << 16;
        return (AW > 16) ? (hi_part | AW'(a16)) : AW'(a16);
    endfunction

    // Bank-0 address used for operand/pointer fetches and program targets.
    function automatic logic [AW-1:0] bank0(input logic [15:0] a16);
        return AW'(a16);
    endfunction

    // Zero-page style sum: wraps inside page 0 unless ZP_WRAP is cleared.
    function automatic logic [15:0] zp_sum(input logic [7:0] base,
                                           input logic [7:0] off);
        logic [15:0] full;
        full = {8'h00, base} + {8'h00, off};
        return ZP_WRAP ? {8'h00, full[7:0]} : full;
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    mode_q, mode_d;
    logic          force_q, force_d;
    logic [7:0]    lo_q, lo_d;       // operand low byte / pointer low / fixed low
    logic [7:0]    hi_q, hi_d;       // operand high byte / pointer high
    logic [7:0]    tl_q, tl_d;       // target low byte read in PLO
    logic          carry_q, carry_d; // carry out of the low-byte index add
    logic [AW-1:0] ea_q;
    logic          pgx_q;

    logic [7:0]    idx_s;
    logic [8:0]    lo_sum_s;
    logic [8:0]    tl_sum_s;
    logic [15:0]   pc_inc_s;
    logic [15:0]   rel_s;
    logic [15:0]   phi_ptr_s;
    logic [AW-1:0] addr_s;
    logic [AW-1:0] ea_s;
    logic          pgx_s;
    logic          pc_adv_s;
    logic          done_s;

    assign idx_s    = ((mode_q == M_ZPX) || (mode_q == M_ABX) || (mode_q == M_NDX)) ? x_i : y_i;
    assign lo_sum_s = {1'b0, lo_q} + {1'b0, idx_s};
    assign tl_sum_s = {1'b0, tl_q} + {1'b0, idx_s};
    assign pc_inc_s = pc_i + 16'd1;
    assign rel_s    = pc_inc_s + {{8{din_i[7]}}, din_i};

    // Address of the pointer high-byte read in PHI.
    always_comb begin
        phi_ptr_s = {hi_q, lo_q + 8'd1};
        case (mode_q)
            M_IND: begin
`ifdef NMOS_JMP_BUG_EN
                phi_ptr_s = {hi_q, lo_q + 8'd1};
`else
                phi_ptr_s = {hi_q, lo_q} + 16'd1;
`endif
            end
            M_NDX: begin
                phi_ptr_s = ZP_WRAP ? {hi_q, lo_q + 8'd1} : ({hi_q, lo_q} + 16'd1);
            end
            default: begin
                phi_ptr_s = {hi_q, lo_q + 8'd1};
            end
        endcase
    end

    // Sequencer next state, bus address and completion outputs.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        force_d  = force_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        tl_d     = tl_q;
        carry_d  = carry_q;
        addr_s   = bank0(pc_i);
        pc_adv_s = 1'b0;
        done_s   = 1'b0;
        ea_s     = ea_q;
        pgx_s    = pgx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_OP1;
                    mode_d  = mode_i;
                    force_d = force_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OP1: begin
                addr_s = bank0(pc_i);
                if (ready_i) begin
                    pc_adv_s = 1'b1;
                    lo_d     = din_i;
                    hi_d     = 8'h00;
                    case (mode_q)
                        M_ZP: begin
                            done_s  = 1'b1;
                            ea_s    = data_addr(dbank_i, {8'h00, din_i});
                            pgx_s   = 1'b0;
                            state_d = S_IDLE;
                        end
                        M_ZPX, M_ZPY, M_NDX: begin
                            state_d = S_DUMMY;
                        end
                        M_ABS, M_ABX, M_ABY, M_IND: begin
                            state_d = S_OP2;
                        end
                        M_NDY: begin
                            state_d = S_PLO;
                        end
                        M_REL: begin
                            // Branch targets live in program space (bank 0).
                            done_s  = 1'b1;
                            ea_s    = bank0(rel_s);
                            pgx_s   = (rel_s[15:8] != pc_inc_s[15:8]);
                            state_d = S_IDLE;
                        end
                        default: begin
                            // IMM and undefined codes: the operand itself is at pc.
                            done_s  = 1'b1;
                            ea_s    = bank0(pc_i);
                            pgx_s   = 1'b0;
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_OP1;
                end
            end
            S_OP2: begin
                addr_s = bank0(pc_i);
                if (ready_i) begin
                    pc_adv_s = 1'b1;
                    hi_d     = din_i;
                    case (mode_q)
                        M_ABS: begin
                            done_s  = 1'b1;
                            ea_s    = data_addr(dbank_i, {din_i, lo_q});
                            pgx_s   = 1'b0;
                            state_d = S_IDLE;
                        end
                        M_ABX, M_ABY: begin
                            if (lo_sum_s[8] || force_q) begin
                                // Keep the uncorrected low byte for the dummy read.
                                lo_d    = lo_sum_s[7:0];
                                carry_d = lo_sum_s[8];
                                state_d = S_FIX;
                            end else begin
                                done_s  = 1'b1;
                                ea_s    = data_addr(dbank_i, {din_i, lo_sum_s[7:0]});
                                pgx_s   = 1'b0;
                                state_d = S_IDLE;
                            end
                        end
                        default: begin
                            state_d = S_PLO;
                        end
                    endcase
                end else begin
                    state_d = S_OP2;
                end
            end
            S_DUMMY: begin
                if (mode_q == M_NDX) begin
                    addr_s = bank0({8'h00, lo_q});
                end else begin
                    addr_s = data_addr(dbank_i, {8'h00, lo_q});
                end
                if (ready_i) begin
                    if (mode_q == M_NDX) begin
                        {hi_d, lo_d} = zp_sum(lo_q, idx_s);
                        state_d      = S_PLO;
                    end else begin
                        done_s  = 1'b1;
                        ea_s    = data_addr(dbank_i, zp_sum(lo_q, idx_s));
                        pgx_s   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DUMMY;
                end
            end
            S_PLO: begin
                addr_s = bank0({hi_q, lo_q});
                if (ready_i) begin
                    tl_d    = din_i;
                    state_d = S_PHI;
                end else begin
                    state_d = S_PLO;
                end
            end
            S_PHI: begin
                addr_s = bank0(phi_ptr_s);
                if (ready_i) begin
                    case (mode_q)
                        M_NDY: begin
                            if (tl_sum_s[8] || force_q) begin
                                lo_d    = tl_sum_s[7:0];
                                hi_d    = din_i;
                                carry_d = tl_sum_s[8];
                                state_d = S_FIX;
                            end else begin
                                done_s  = 1'b1;
                                ea_s    = data_addr(dbank_i, {din_i, tl_sum_s[7:0]});
                                pgx_s   = 1'b0;
                                state_d = S_IDLE;
                            end
                        end
                        M_IND: begin
                            // Jump target: bank bits are forced to zero.
                            done_s  = 1'b1;
                            ea_s    = bank0({din_i, tl_q});
                            pgx_s   = 1'b0;
                            state_d = S_IDLE;
                        end
                        default: begin
                            done_s  = 1'b1;
                            ea_s    = data_addr(dbank_i, {din_i, tl_q});
                            pgx_s   = 1'b0;
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_PHI;
                end
            end
            S_FIX: begin
                // Dummy read at the un-carried address, then the corrected EA.
                addr_s = data_addr(dbank_i, {hi_q, lo_q});
                if (ready_i) begin
                    done_s  = 1'b1;
                    ea_s    = data_addr(dbank_i, {hi_q + {7'b0000000, carry_q}, lo_q});
                    pgx_s   = carry_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FIX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            mode_q  <= 4'd0;
            force_q <= 1'b0;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            tl_q    <= 8'h00;
            carry_q <= 1'b0;
            ea_q    <= '0;
            pgx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            force_q <= force_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            tl_q    <= tl_d;
            carry_q <= carry_d;
            ea_q    <= ea_s;
            pgx_q   <= pgx_s;
        end
    end

    assign address_o = addr_s;
    assign rd_o      = (state_q != S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_s;
    assign ea_o      = ea_s;
    assign pc_adv_o  = pc_adv_s;
    assign page_x_o  = pgx_s;

endmodule

// File: tb/tb_mos6502_agu.sv
module tb_mos6502_agu;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [3:0]  mode;
    logic        frc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] pc;
    logic [0:0]  dbank;
    logic [7:0]  din;
    logic        ready;
    logic [15:0] address;
    logic        rd;
    logic        busy;
    logic        done;
    logic [15:0] ea;
    logic        pc_adv;
    logic        page_x;

    logic [7:0]  mem [0:65535];

    int nvec;
    int nbad;

    // hand-computed expectations for directed transactions
    logic pin_v;
    int   pin_ea;
    int   pin_pgx;
    int   pin_n;

    // compare-process state
    logic       act;
    logic       pend;
    int         k;
    int         e_addr [0:3];
    int         e_n;
    int         e_npc;
    int         e_ea;
    int         e_pgx;
    int         last_ea;
    logic [3:0] lat_mode;
    logic       lat_f;
    int         lat_x;
    int         lat_y;
    int         lat_pc;

    mos6502_agu #(.AW(16), .ZP_WRAP(1'b1)) dut (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .start_i   (start),
        .mode_i    (mode),
        .force_i   (frc),
        .x_i       (x),
        .y_i       (y),
        .pc_i      (pc),
        .dbank_i   (dbank),
        .din_i     (din),
        .ready_i   (ready),
        .address_o (address),
        .rd_o      (rd),
        .busy_o    (busy),
        .done_o    (done),
        .ea_o      (ea),
        .pc_adv_o  (pc_adv),
        .page_x_o  (page_x)
    );

    assign din = mem[address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: address of every sequence cycle, EA, page flag and
    // number of operand bytes, derived directly from the addressing rules.
    task automatic compute_expect();
        int p, p1, b1, b2, idx, s, pt, lo, hi, ptr, a2;
        p   = lat_pc;
        p1  = (p + 1) % 65536;
        b1  = int'(mem[p]);
        b2  = int'(mem[p1]);
        idx = (lat_mode == 4'd2 || lat_mode == 4'd5 || lat_mode == 4'd7) ? lat_x : lat_y;
        e_pgx = 0; e_npc = 1; e_n = 1; e_addr[0] = p; e_ea = p;
        case (lat_mode)
            4'd1: e_ea = b1;
            4'd2, 4'd3: begin
                e_n = 2; e_addr[1] = b1; e_ea = (b1 + idx) % 256;
            end
            4'd4: begin
                e_n = 2; e_npc = 2; e_addr[1] = p1; e_ea = b2 * 256 + b1;
            end
            4'd5, 4'd6: begin
                s = b2 * 256 + b1 + idx;
                e_pgx = ((s / 256) != b2) ? 1 : 0;
                e_npc = 2; e_addr[1] = p1; e_ea = s % 65536;
                if (e_pgx == 1 || lat_f) begin
                    e_n = 3; e_addr[2] = b2 * 256 + (b1 + idx) % 256;
                end else begin
                    e_n = 2;
                end
            end
            4'd7: begin
                pt = (b1 + lat_x) % 256;
                lo = int'(mem[pt]); hi = int'(mem[(pt + 1) % 256]);
                e_n = 4; e_addr[1] = b1; e_addr[2] = pt; e_addr[3] = (pt + 1) % 256;
                e_ea = hi * 256 + lo;
            end
            4'd8: begin
                lo = int'(mem[b1]); hi = int'(mem[(b1 + 1) % 256]);
                s = hi * 256 + lo + lat_y;
                e_pgx = ((s / 256) != hi) ? 1 : 0;
                e_addr[1] = b1; e_addr[2] = (b1 + 1) % 256; e_ea = s % 65536;
                if (e_pgx == 1 || lat_f) begin
                    e_n = 4; e_addr[3] = hi * 256 + (lo + lat_y) % 256;
                end else begin
                    e_n = 3;
                end
            end
            4'd9: begin
                ptr = b2 * 256 + b1;
`ifdef NMOS_JMP_BUG_EN
                a2 = b2 * 256 + (b1 + 1) % 256;
`else
                a2 = (ptr + 1) % 65536;
`endif
                e_n = 4; e_npc = 2; e_addr[1] = p1; e_addr[2] = ptr; e_addr[3] = a2;
                e_ea = int'(mem[a2]) * 256 + int'(mem[ptr]);
            end
            4'd10: begin
                s = (p1 + ((b1 >= 128) ? b1 - 256 : b1) + 65536) % 65536;
                e_ea = s;
                e_pgx = ((s / 256) != (p1 / 256)) ? 1 : 0;
            end
            default: e_ea = p;
        endcase
    endtask

    // Compare process: checks every DUT output on every falling edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            act = 1'b0; pend = 1'b0; last_ea = 0;
            chk("rst_busy", int'(busy), 0);
            chk("rst_rd", int'(rd), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_pc_adv", int'(pc_adv), 0);
            chk("rst_ea", int'(ea), 0);
            chk("rst_page_x", int'(page_x), 0);
            chk("rst_addr", int'(address), int'(pc));
        end else begin
            if (pend) begin
                compute_expect();
                pend = 1'b0; act = 1'b1; k = 0;
                if (pin_v) begin
                    chk("pin_ea", e_ea, pin_ea);
                    chk("pin_page_x", e_pgx, pin_pgx);
                    chk("pin_cycles", e_n, pin_n);
                end
            end
            if (act) begin
                chk("busy", int'(busy), 1);
                chk("rd", int'(rd), 1);
                chk("addr", int'(address), e_addr[k]);
                chk("pc_adv", int'(pc_adv), (ready && k < e_npc) ? 1 : 0);
                chk("done", int'(done), (ready && k == e_n - 1) ? 1 : 0);
                if (ready && k == e_n - 1) begin
                    chk("ea", int'(ea), e_ea);
                    chk("page_x", int'(page_x), e_pgx);
                    last_ea = e_ea;
                    act = 1'b0;
                end else begin
                    chk("ea_hold", int'(ea), last_ea);
                end
                if (ready) k++;
            end else begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_rd", int'(rd), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_pc_adv", int'(pc_adv), 0);
                chk("idle_addr", int'(address), int'(pc));
                chk("idle_ea", int'(ea), last_ea);
            end
            if (!act && !busy && start) begin
                lat_mode = mode; lat_f = frc; lat_x = int'(x); lat_y = int'(y); lat_pc = int'(pc);
                pend = 1'b1;
            end
        end
    end

    task automatic pin(input int pe, input int pp, input int pn);
        pin_v = 1'b1; pin_ea = pe; pin_pgx = pp; pin_n = pn;
    endtask

    // rmode: 0 ready always high, 1 random ready and junk starts, 2 ready low 3 cycles
    task automatic run_txn(input logic [3:0] m, input logic f, input logic [7:0] xv,
                           input logic [7:0] yv, input logic [15:0] pcv, input int rmode);
        logic adv;
        mode = m; frc = f; x = xv; y = yv; pc = pcv; start = 1'b1; ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 64 && busy; c++) begin
            if (rmode == 2) ready = (c < 3) ? 1'b0 : 1'b1;
            else if (rmode == 1) ready = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            else ready = 1'b1;
            if (rmode == 1 && $urandom_range(0, 4) == 0) begin
                start = 1'b1; mode = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            adv = pc_adv;
            @(posedge clock); #1;
            if (adv) pc = pc + 16'd1;
        end
        start = 1'b0; ready = 1'b1; pin_v = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        logic [15:0] pv;
        nvec = 0; nbad = 0;
        act = 1'b0; pend = 1'b0; k = 0; last_ea = 0;
        reset_n = 1'b0; start = 1'b0; mode = 4'd0; frc = 1'b0; x = 8'h00; y = 8'h00;
        pc = 16'h0000; dbank = 1'b0; ready = 1'b1;
        pin_v = 1'b0; pin_ea = 0; pin_pgx = 0; pin_n = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // ABX across a page, then within the page, then forced
        mem[16'h0400] = 8'hF8; mem[16'h0401] = 8'h12;
        pin(32'h1308, 1, 3); run_txn(4'd5, 1'b0, 8'h10, 8'h00, 16'h0400, 0);
        pin(32'h12F9, 0, 2); run_txn(4'd5, 1'b0, 8'h01, 8'h00, 16'h0400, 0);
        pin(32'h12F9, 0, 3); run_txn(4'd5, 1'b1, 8'h01, 8'h00, 16'h0400, 0);

        // NDX with the pointer wrapping in page zero
        mem[16'h0500] = 8'hFF; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        pin(32'h1234, 0, 4); run_txn(4'd7, 1'b0, 8'h01, 8'h00, 16'h0500, 0);

        // IND through a page-end pointer
        mem[16'h0600] = 8'hFF; mem[16'h0601] = 8'h02;
        mem[16'h02FF] = 8'h00; mem[16'h0200] = 8'h80; mem[16'h0300] = 8'h90;
`ifdef NMOS_JMP_BUG_EN
        pin(32'h8000, 0, 4);
`else
        pin(32'h9000, 0, 4);
`endif
        run_txn(4'd9, 1'b0, 8'h00, 8'h00, 16'h0600, 0);

        // ZP with ready low for three cycles in OP1
        mem[16'h0900] = 8'h42;
        pin(32'h0042, 0, 1); run_txn(4'd1, 1'b0, 8'h00, 8'h00, 16'h0900, 2);

        // ZPX wrap, NDY with page cross
        mem[16'h0A00] = 8'hF0;
        pin(32'h0010, 0, 2); run_txn(4'd2, 1'b0, 8'h20, 8'h00, 16'h0A00, 0);
        mem[16'h0B00] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h30;
        pin(32'h3110, 1, 4); run_txn(4'd8, 1'b0, 8'h00, 8'h20, 16'h0B00, 0);

        // REL forward across a page and backward within it
        mem[16'h10FD] = 8'h05;
        pin(32'h1103, 1, 1); run_txn(4'd10, 1'b0, 8'h00, 8'h00, 16'h10FD, 0);
        mem[16'h10FD] = 8'hFE;
        pin(32'h10FC, 0, 1); run_txn(4'd10, 1'b0, 8'h00, 8'h00, 16'h10FD, 0);

        // Reset during NDY PLO, then IMM
        mem[16'h0700] = 8'h20;
        mode = 4'd8; frc = 1'b0; x = 8'h00; y = 8'h05; pc = 16'h0700; start = 1'b1; ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        pc = pc + 16'd1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        pin(32'h0800, 0, 1); run_txn(4'd0, 1'b0, 8'h00, 8'h00, 16'h0800, 0);

        // Randomized transactions
        for (int t = 0; t < 300; t++) begin
            pv = 16'($urandom);
            mem[pv] = 8'($urandom);
            mem[pv + 16'd1] = 8'($urandom);
            run_txn(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom),
                    8'($urandom), pv, (t % 3 == 0) ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
